// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals shared by imem_dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding stages and memory.
interface imem_dmem_arbiter_if;
  logic        ifu_req_valid;
  logic [63:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_flush;
  logic [31:0] ifu_instr;
  logic        ifu_instr_valid;

  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rsp_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_flush,
    output ifu_req_ready, ifu_instr, ifu_instr_valid,
    input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_flush,
    input  ifu_req_ready, ifu_instr, ifu_instr_valid,
    output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Single-outstanding arbiter sharing one 64-bit memory port between fetch and load/store.
// Optional IMEM_ARB_AGING_EN: after AGE_MAX back-to-back LSU grants a waiting fetch goes first.
module imem_dmem_arbiter #(
  parameter int          AGE_MAX   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                clk,
  input logic                rst,
  imem_dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IFU = 2'd1, OWN_LSU = 2'd2} owner_t;

  state_t      state_r;
  owner_t      owner_r;
  logic        drop_r;
  logic        mem_req_valid_r;
  logic [63:0] mem_req_addr_r;
  logic        mem_req_wen_r;
  logic [63:0] mem_req_wdata_r;
  logic [7:0]  mem_req_wmask_r;
  logic [31:0] ifu_instr_r;
  logic        ifu_instr_valid_r;
  logic        lsu_rsp_valid_r;
  logic [63:0] lsu_rsp_rdata_r;

  logic ifu_elig_s;
  logic ifu_first_s;
  logic grant_ifu_s;
  logic grant_lsu_s;
  logic ifu_addr_unused_s;

  assign ifu_elig_s        = bus.ifu_req_valid & ~bus.ifu_flush;
  assign ifu_addr_unused_s = ^bus.ifu_req_addr[1:0];

`ifdef IMEM_ARB_AGING_EN
  localparam int              AGE_W   = $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0] age_r;

  // Count LSU grants that leave a fetch waiting; saturates at AGE_TOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_r <= {AGE_W{1'b0}};
    end else if (grant_ifu_s || (state_r == IDLE && !bus.ifu_req_valid)) begin
      age_r <= {AGE_W{1'b0}};
    end else if (grant_lsu_s && bus.ifu_req_valid && age_r != AGE_TOP) begin
      age_r <= age_r + AGE_W'(1);
    end else begin
      age_r <= age_r;
    end
  end

  assign ifu_first_s = ifu_elig_s & (age_r == AGE_TOP);
`else
  localparam int age_max_unused = AGE_MAX;
  assign ifu_first_s = 1'b0;
`endif

  // IDLE arbitration: LSU wins unless an aged fetch has been promoted.
  always_comb begin
    grant_ifu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (state_r == IDLE) begin
      if (ifu_first_s) begin
        grant_ifu_s = 1'b1;
      end else if (bus.lsu_req_valid) begin
        grant_lsu_s = 1'b1;
      end else if (ifu_elig_s) begin
        grant_ifu_s = 1'b1;
      end else begin
        grant_ifu_s = 1'b0;
      end
    end else begin
      grant_lsu_s = 1'b0;
    end
  end

  // Transaction sequencer: latch request, present it, collect and route the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      owner_r           <= OWN_NONE;
      drop_r            <= 1'b0;
      mem_req_valid_r   <= 1'b0;
      mem_req_addr_r    <= 64'd0;
      mem_req_wen_r     <= 1'b0;
      mem_req_wdata_r   <= 64'd0;
      mem_req_wmask_r   <= 8'd0;
      ifu_instr_r       <= NOP_INSTR;
      ifu_instr_valid_r <= 1'b0;
      lsu_rsp_valid_r   <= 1'b0;
      lsu_rsp_rdata_r   <= 64'd0;
    end else begin
      ifu_instr_valid_r <= 1'b0;
      lsu_rsp_valid_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          drop_r <= 1'b0;
          if (grant_lsu_s) begin
            owner_r         <= OWN_LSU;
            mem_req_valid_r <= 1'b1;
            mem_req_addr_r  <= bus.lsu_req_addr;
            mem_req_wen_r   <= bus.lsu_req_wen;
            mem_req_wdata_r <= bus.lsu_req_wdata;
            mem_req_wmask_r <= bus.lsu_req_wmask;
            state_r         <= REQ;
          end else if (grant_ifu_s) begin
            owner_r         <= OWN_IFU;
            mem_req_valid_r <= 1'b1;
            mem_req_addr_r  <= {bus.ifu_req_addr[63:2], 2'b00};
            mem_req_wen_r   <= 1'b0;
            mem_req_wdata_r <= 64'd0;
            mem_req_wmask_r <= 8'd0;
            state_r         <= REQ;
          end else begin
            owner_r <= OWN_NONE;
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (owner_r == OWN_IFU && bus.ifu_flush) begin
            drop_r <= 1'b1;
          end
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state_r         <= RSP;
          end
        end
        RSP: begin
          if (bus.mem_rsp_valid) begin
            state_r <= IDLE;
            owner_r <= OWN_NONE;
            drop_r  <= 1'b0;
            if (owner_r == OWN_LSU) begin
              lsu_rsp_valid_r <= 1'b1;
              lsu_rsp_rdata_r <= mem_req_wen_r ? 64'd0 : bus.mem_rsp_rdata;
            end else if (owner_r == OWN_IFU && !drop_r && !bus.ifu_flush) begin
              // A flush in the response cycle itself still counts as stale.
              ifu_instr_valid_r <= 1'b1;
              ifu_instr_r       <= mem_req_addr_r[2] ? bus.mem_rsp_rdata[63:32]
                                                     : bus.mem_rsp_rdata[31:0];
            end
          end else if (owner_r == OWN_IFU && bus.ifu_flush) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r         <= IDLE;
          owner_r         <= OWN_NONE;
          drop_r          <= 1'b0;
          mem_req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ifu_req_ready   = grant_ifu_s;
  assign bus.lsu_req_ready   = grant_lsu_s;
  assign bus.ifu_instr       = ifu_instr_r;
  assign bus.ifu_instr_valid = ifu_instr_valid_r;
  assign bus.lsu_rsp_valid   = lsu_rsp_valid_r;
  assign bus.lsu_rsp_rdata   = lsu_rsp_rdata_r;
  assign bus.mem_req_valid   = mem_req_valid_r;
  assign bus.mem_req_addr    = mem_req_addr_r;
  assign bus.mem_req_wen     = mem_req_wen_r;
  assign bus.mem_req_wdata   = mem_req_wdata_r;
  assign bus.mem_req_wmask   = mem_req_wmask_r;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_imem_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_dmem_arbiter_if bus ();

  imem_dmem_arbiter #(.AGE_MAX(4), .NOP_INSTR(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        is_lsu;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_stall = 0;
  int          mem_rsp_delay = 0;
  logic [63:0] mem_rdata = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_lsu, input logic [63:0] data);
    exp_t e;
    e.is_lsu = is_lsu;
    e.data   = data;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for the chosen ready; assumes the caller sits #1 after a negedge.
  task automatic wait_ready(input logic lsu, output int k);
    k = 0;
    while ((lsu ? bus.lsu_req_ready : bus.ifu_req_ready) !== 1'b1 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL grant_timeout: lsu=%0d got no ready within %0d cycles", lsu, k);
    end
  endtask

  // Zero-wait by default; mem_stall delays accept, mem_rsp_delay delays the response.
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1 && !rst) begin
        repeat (mem_stall) @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        repeat (mem_rsp_delay) @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = mem_rdata;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 64'd0;
      end
    end
  end

  // Scoreboard monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    if (!rst) begin
      if (bus.ifu_instr_valid === 1'b1 && bus.lsu_rsp_valid === 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL strobe_overlap: got both strobes high, required at most one");
      end else if (bus.ifu_instr_valid === 1'b1 || bus.lsu_rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got strobe lsu=%0d with empty scoreboard", bus.lsu_rsp_valid);
        end else begin
          e   = sb_q.pop_front();
          act = bus.lsu_rsp_valid ? bus.lsu_rsp_rdata : {32'd0, bus.ifu_instr};
          check("rsp_source", {63'd0, bus.lsu_rsp_valid}, {63'd0, e.is_lsu});
          check("rsp_data", act, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_fetch(input logic [63:0] addr);
    int k;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = addr;
    #1;
    wait_ready(1'b0, k);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Fetch whose data must be discarded: flush pulsed k cycles after the grant.
  task automatic fetch_flushed(input logic [63:0] addr, input int delay, input int kf);
    int k;
    mem_rsp_delay = delay;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = addr;
    #1;
    wait_ready(1'b0, k);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    for (int j = 2; j <= kf; j++) @(negedge clk);
    bus.ifu_flush = 1'b1;
    @(negedge clk);
    bus.ifu_flush = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("flush_no_strobe", {63'd0, bus.ifu_instr_valid}, 64'd0);
      check("flush_instr_held", {32'd0, bus.ifu_instr}, 64'h0000_0000_CCCC_DDDD);
      @(negedge clk);
    end
    mem_rsp_delay = 0;
  endtask

  initial begin
    int          k;
    int          g;
    int          cyc;
    logic [5:0]  seq_ifu;
    logic [5:0]  exp_seq_ifu;

    bus.ifu_req_valid = 1'b0;
    bus.ifu_req_addr  = 64'd0;
    bus.ifu_flush     = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_addr  = 64'd0;
    bus.lsu_req_wdata = 64'd0;
    bus.lsu_req_wmask = 8'd0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_instr", {32'd0, bus.ifu_instr}, 64'h13);
    check("rst_instr_valid", {63'd0, bus.ifu_instr_valid}, 64'd0);
    check("rst_lsu_valid", {63'd0, bus.lsu_rsp_valid}, 64'd0);
    check("rst_lsu_rdata", bus.lsu_rsp_rdata, 64'd0);
    check("rst_mem_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    check("rst_mem_addr", bus.mem_req_addr, 64'd0);
    check("rst_mem_wmask", {56'd0, bus.mem_req_wmask}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, zero-wait memory, strobe 3 cycles after accept
    mem_rdata = 64'h1111_2222_3333_4444;
    push_exp(1'b0, 64'h0000_0000_1111_2222);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h0000_0000_8000_0004;
    #1;
    wait_ready(1'b0, k);
    check("t1_lsu_ready_low", {63'd0, bus.lsu_req_ready}, 64'd0);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    #1;
    check("t1_mem_valid", {63'd0, bus.mem_req_valid}, 64'd1);
    check("t1_mem_addr", bus.mem_req_addr, 64'h0000_0000_8000_0004);
    check("t1_mem_wen", {63'd0, bus.mem_req_wen}, 64'd0);
    check("t1_strobe_n1", {63'd0, bus.ifu_instr_valid}, 64'd0);
    @(negedge clk);
    #1;
    check("t1_strobe_n2", {63'd0, bus.ifu_instr_valid}, 64'd0);
    @(negedge clk);
    #1;
    check("t1_strobe_n3", {63'd0, bus.ifu_instr_valid}, 64'd1);
    check("t1_instr", {32'd0, bus.ifu_instr}, 64'h0000_0000_1111_2222);
    @(negedge clk);
    #1;
    check("t1_strobe_n4", {63'd0, bus.ifu_instr_valid}, 64'd0);
    @(negedge clk);

    // Simultaneous requests: LSU first, fetch granted in the next IDLE cycle
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    push_exp(1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    push_exp(1'b0, 64'h0000_0000_CCCC_DDDD);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h0000_0000_8000_0008;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_addr  = 64'h0000_0000_8000_1000;
    #1;
    check("t2_lsu_ready", {63'd0, bus.lsu_req_ready}, 64'd1);
    check("t2_ifu_ready", {63'd0, bus.ifu_req_ready}, 64'd0);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    #1;
    check("t2_mem_addr", bus.mem_req_addr, 64'h0000_0000_8000_1000);
    check("t2_mem_wen", {63'd0, bus.mem_req_wen}, 64'd0);
    wait_ready(1'b0, k);
    check("t2_ifu_grant_gap", 64'(k), 64'd2);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Store with partial mask; response data must be zero
    push_exp(1'b1, 64'd0);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_addr  = 64'h0000_0000_8000_2000;
    bus.lsu_req_wdata = 64'h0123_4567_89AB_CDEF;
    bus.lsu_req_wmask = 8'h0F;
    #1;
    wait_ready(1'b1, k);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    #1;
    check("t2_st_valid", {63'd0, bus.mem_req_valid}, 64'd1);
    check("t2_st_wen", {63'd0, bus.mem_req_wen}, 64'd1);
    check("t2_st_wmask", {56'd0, bus.mem_req_wmask}, 64'h0F);
    check("t2_st_wdata", bus.mem_req_wdata, 64'h0123_4567_89AB_CDEF);
    repeat (3) @(negedge clk);

    // Flush drops stale fetches (flush in RSP, and flush in the response cycle)
    mem_rdata = 64'hDEAD_BEEF_FEED_FACE;
    fetch_flushed(64'h0000_0000_8000_0040, 2, 2);
    fetch_flushed(64'h0000_0000_8000_0044, 1, 3);
    mem_rdata = 64'h5555_6666_7777_8888;
    push_exp(1'b0, 64'h0000_0000_7777_8888);
    do_fetch(64'h0000_0000_8000_0100);
    check("t3_refetch_instr", {32'd0, bus.ifu_instr}, 64'h0000_0000_7777_8888);

    // Backpressure: request held stable, no ready to anyone
    mem_stall = 5;
    mem_rdata = 64'h9999_AAAA_BBBB_CCCC;
    push_exp(1'b1, 64'd0);
    push_exp(1'b0, 64'h0000_0000_9999_AAAA);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_addr  = 64'h0000_0000_8000_3000;
    bus.lsu_req_wdata = 64'hCAFE_F00D_1234_5678;
    bus.lsu_req_wmask = 8'hFF;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h0000_0000_8000_0104;
    #1;
    wait_ready(1'b1, k);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("t4_bp_valid", {63'd0, bus.mem_req_valid}, 64'd1);
      check("t4_bp_addr", bus.mem_req_addr, 64'h0000_0000_8000_3000);
      check("t4_bp_wdata", bus.mem_req_wdata, 64'hCAFE_F00D_1234_5678);
      check("t4_bp_readies", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
    end
    mem_stall = 0;
    wait_ready(1'b0, k);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Async reset while waiting for the response
    mem_rsp_delay = 3;
    mem_rdata = 64'h1234_5678_9ABC_DEF0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h0000_0000_8000_0200;
    #1;
    wait_ready(1'b0, k);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_instr", {32'd0, bus.ifu_instr}, 64'h13);
    check("t5_rst_mem_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    check("t5_rst_strobes", {62'd0, bus.ifu_instr_valid, bus.lsu_rsp_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t5_late_rsp_ignored", {62'd0, bus.ifu_instr_valid, bus.lsu_rsp_valid}, 64'd0);
      @(negedge clk);
    end
    mem_rsp_delay = 0;

    // Aging: both requesters held
    mem_rdata = 64'h0A0B_0C0D_0E0F_1011;
`ifdef IMEM_ARB_AGING_EN
    exp_seq_ifu = 6'b01_0000;
`else
    exp_seq_ifu = 6'b00_0000;
`endif
    seq_ifu = 6'd0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_addr  = 64'h0000_0000_8000_4000;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h0000_0000_8000_0300;
    g   = 0;
    cyc = 0;
    while (g < 6 && cyc < 60) begin
      #1;
      if (bus.lsu_req_ready === 1'b1 && bus.ifu_req_ready === 1'b1) begin
        check("t6_dual_ready", 64'd2, 64'd1);
      end else if (bus.lsu_req_ready === 1'b1) begin
        push_exp(1'b1, 64'h0A0B_0C0D_0E0F_1011);
        g++;
      end else if (bus.ifu_req_ready === 1'b1) begin
        push_exp(1'b0, 64'h0000_0000_0E0F_1011);
        seq_ifu[g] = 1'b1;
        g++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b0;
    check("t6_grant_count", 64'(g), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_grant_%0d_is_ifu", i), {63'd0, seq_ifu[i]}, {63'd0, exp_seq_ifu[i]});
    end
    repeat (5) @(negedge clk);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one 64-bit memory port between the fetch path (instruction reads) and the load/store path (data reads and writes).
- Sequences each access as a single outstanding transaction: request, then accept, then response.
- Returns instructions to the fetch stage with an `ifu_instr_valid` strobe; this is the stage's `instr_valid` input.
- Drops fetch responses that a redirect or flush has made stale.
- Sits between the fetch/LSU stages and the memory bus adapter.

Parameters:
- AGE_MAX, 4: maximum consecutive LSU grants while IFU is waiting. Used only with the optional feature.
- NOP_INSTR, 32'h00000013: value of ifu_instr at reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ifu_req_valid  in  1  fetch request; held until accepted
- ifu_req_addr  in  64  fetch address, 4-byte aligned
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_flush  in  1  redirect/flush; kills any pending fetch
- ifu_instr  out  32  fetched instruction
- ifu_instr_valid  out  1  one-cycle strobe: ifu_instr is valid
- lsu_req_valid  in  1  data request; held until accepted
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_addr  in  64  data address
- lsu_req_wdata  in  64  store data
- lsu_req_wmask  in  8  store byte mask
- lsu_req_ready  out  1  data request accepted this cycle
- lsu_rsp_valid  out  1  one-cycle strobe: load data valid, or store done
- lsu_rsp_rdata  out  64  load data; 0 for stores
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  64  memory address
- mem_req_wen  out  1  memory write enable
- mem_req_wdata  out  64  memory write data
- mem_req_wmask  out  8  memory byte mask
- mem_rsp_valid  in  1  memory response strobe
- mem_rsp_rdata  in  64  memory read data

Behaviour:
- **Reset (async, rst=1):**
  - state=IDLE, owner=NONE, drop=0, age counter=0.
  - mem_req_valid/wen=0; mem_req_addr/wdata/wmask=0.
  - ifu_instr=NOP_INSTR; ifu_instr_valid=0.
  - lsu_rsp_valid=0; lsu_rsp_rdata=0.
  - Reset mid-transaction abandons it. Any later mem_rsp_valid arriving in IDLE is ignored.
- **FSM states:** IDLE, REQ, RSP.
- **IDLE:**
  - Arbitration is combinational.
  - Priority is LSU over IFU.
  - IFU is eligible only if ifu_req_valid=1 and ifu_flush=0.
  - The winner gets its ready=1 in this cycle. Its address, wen, wdata and wmask are latched into the mem_req_* registers, owner is recorded, and the FSM goes to REQ.
  - IFU requests latch wen=0, wmask=0, wdata=0.
  - No request: stay in IDLE; both readies=0.
  - Readies are asserted only in IDLE.
- **REQ:**
  - mem_req_valid=1; the mem_req_* fields are stable.
  - On mem_req_ready=1, deassert mem_req_valid on the next edge and go to RSP.
- **RSP:**
  - Wait for mem_rsp_valid=1, then go to IDLE on the same edge.
  - owner=LSU: next cycle, lsu_rsp_valid=1 for one cycle. lsu_rsp_rdata = mem_rsp_rdata for loads, 0 for stores.
  - owner=IFU with drop=0: next cycle, ifu_instr_valid=1 for one cycle.
    - ifu_instr = latched addr[2] ? rdata[63:32] : rdata[31:0].
  - owner=IFU with drop=1: no strobe; ifu_instr holds its old value.
- **Latency:** request accepted in cycle N; mem_req_valid in N+1; with zero-wait memory the response strobe is at N+3 (response at N+2, registered). The next grant is possible in N+3.
- **Flush and drop:**
  - ifu_flush=1 while owner=IFU in REQ or RSP sets drop=1. This includes the cycle in which mem_rsp_valid arrives.
  - drop clears on return to IDLE.
  - A flush never cancels a memory request already presented; the transaction completes and its data is discarded.
  - ifu_flush has no effect on an LSU-owned transaction.
- **Strobes:** ifu_instr_valid and lsu_rsp_valid are never both 1. Each is 0 in every cycle except the single cycle after its response.
- **Unaligned fetch:** ifu_req_addr[1:0] are ignored.

Optional Feature:
- **IMEM_ARB_AGING_EN defined:** an age counter tracks consecutive LSU grants.
  - Width $clog2(AGE_MAX+1).
  - Increments on each LSU grant made while ifu_req_valid=1.
  - Clears on an IFU grant or whenever ifu_req_valid=0 in IDLE.
  - When the counter equals AGE_MAX, IDLE grants IFU ahead of LSU, provided IFU is eligible.
- **Undefined:** strict LSU priority; no counter is present.

Test Plan:
- **Single fetch:** ifu_req_addr=0x8000_0004, mem_rsp_rdata=0x1111_2222_3333_4444 with zero-wait memory -> ifu_req_ready pulses; 3 cycles later ifu_instr=0x1111_2222 and ifu_instr_valid=1 for one cycle.
- **Simultaneous requests:** ifu_req_valid=1 and lsu_req_valid=1 (load to 0x8000_1000) in the same cycle -> lsu_req_ready=1 and ifu_req_ready=0. The LSU response is followed by the IFU grant in the next IDLE cycle. A store with wmask=0x0F drives mem_req_wmask=0x0F and mem_req_wen=1.
- **Flush drops stale fetch:** fetch in RSP with ifu_flush pulsed and mem_rsp_valid 2 cycles later -> ifu_instr_valid stays 0 and ifu_instr unchanged. A following fetch at 0x8000_0100 returns normally.
- **Backpressure:** mem_req_ready held 0 for 5 cycles -> mem_req_valid=1 with constant addr/wdata throughout; no ready pulse to either requester until completion.
- **Async reset mid-transaction:** rst asserted in RSP -> immediate IDLE, ifu_instr=0x13, all strobes 0. A later mem_rsp_valid produces no output strobe.
- **Aging (IMEM_ARB_AGING_EN, AGE_MAX=4):** lsu_req_valid and ifu_req_valid both held 1 -> grants are LSU×4, IFU, then LSU again. With the macro undefined, IFU is never granted while LSU is requesting.
